delivery_game_uc: RTL and testbench

Control unit for the delivery game. It sequences the game datapath through start, continuous map scrolling, periodic ultrasonic velocity measurement with timeout recovery, pause and game over. It sits beside the datapath and drives all of its control inputs (datapath reset, map counting, sensor trigger, delay and timeout counters) from the datapath status flags and two player buttons.

---
 rtl/delivery_game_uc.sv | 192 +++++++++++++++++++
 tb/tb_delivery_game_uc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/delivery_game_uc.sv
// delivery_game_uc: control unit for the delivery game.
// Sequences the datapath through start, continuous map scrolling, periodic
// ultrasonic velocity measurement with timeout recovery, pause and game over.
// Moore FSM: every datapath control is decoded from the state register only.
//
// Handshake note: there is no valid/ready channel here. iniciar and pausar are
// level buttons acted on at their rising edge (in & ~prev). velocity_ready,
// velocity_timeout, end_delay and game_over are sampled every cycle while in
// the states that wait on them. get_velocity is a one-cycle request.
module delivery_game_uc #(
  parameter int MAX_RETRIES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       game_over,
  input  logic       velocity_ready,
  input  logic       velocity_timeout,
  input  logic       end_delay,
  output logic       zera,
  output logic       reset_ultrasonico,
  output logic       count_map,
  output logic       get_velocity,
  output logic       reset_delay,
  output logic       conta_delay,
  output logic       reset_timeout,
  output logic       conta_timeout,
  output logic       jogando,
  output logic       pausado,
  output logic       fim_jogo,
  output logic       sensor_fault,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    MEDIR         = 4'd2,
    ESPERA_MEDIDA = 4'd3,
    RECUPERA      = 4'd4,
    ATRASO        = 4'd5,
    PAUSA         = 4'd6,
    FIM           = 4'd7
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);

  state_t     state_q;
  state_t     state_d;
  logic       iniciar_q;
  logic       pausar_q;
  logic       iniciar_edge;
  logic       pausar_edge;
  logic [2:0] retry_q;
  logic [2:0] retry_inc;
  logic       pause_req_q;
  logic       in_play;

  assign iniciar_edge = iniciar & ~iniciar_q;
  assign pausar_edge  = pausar & ~pausar_q;

  // Saturating increment of the consecutive-timeout count.
  assign retry_inc = (retry_q >= MAX_R) ? MAX_R : retry_q + 3'd1;

  assign in_play = (state_q == MEDIR) || (state_q == ESPERA_MEDIDA) ||
                   (state_q == RECUPERA) || (state_q == ATRASO);

  // Previous-value registers for the two buttons.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iniciar_q <= 1'b0;
      pausar_q  <= 1'b0;
    end else begin
      iniciar_q <= iniciar;
      pausar_q  <= pausar;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; game_over has priority over every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:       if (iniciar_edge) state_d = PREPARA;
      PREPARA:       state_d = MEDIR;
      MEDIR:         state_d = ESPERA_MEDIDA;
      ESPERA_MEDIDA: begin
        if (game_over)             state_d = FIM;
        else if (velocity_ready)   state_d = ATRASO;
        else if (velocity_timeout) state_d = RECUPERA;
      end
      RECUPERA:      state_d = ATRASO;
      ATRASO: begin
        if (game_over)      state_d = FIM;
        else if (end_delay) state_d = pause_req_q ? PAUSA : MEDIR;
      end
      PAUSA:         if (pausar_edge) state_d = MEDIR;
      FIM:           if (iniciar_edge) state_d = PREPARA;
      default:       state_d = INICIAL;
    endcase
  end

  // Retry counter, sticky sensor fault and pending pause request.
  // Entering PREPARA starts a fresh game, so all three are cleared there.
  // A pause request only takes effect at the end of ATRASO so the sensor is
  // never abandoned mid-measurement; it is consumed on entry to PAUSA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_q      <= 3'd0;
      sensor_fault <= 1'b0;
      pause_req_q  <= 1'b0;
    end else if (state_d == PREPARA) begin
      retry_q      <= 3'd0;
      sensor_fault <= 1'b0;
      pause_req_q  <= 1'b0;
    end else begin
      if (state_q == ESPERA_MEDIDA && !game_over && velocity_ready) begin
        retry_q <= 3'd0;
      end else if (state_q == RECUPERA) begin
        retry_q <= retry_inc;
        if (retry_inc == MAX_R) sensor_fault <= 1'b1;
      end
      if (state_d == PAUSA) begin
        pause_req_q <= 1'b0;
      end else if (pausar_edge && in_play) begin
        pause_req_q <= 1'b1;
      end
    end
  end

  // Moore output decode; unlisted outputs stay 0 in each state.
  always_comb begin
    zera              = 1'b0;
    reset_ultrasonico = 1'b0;
    count_map         = 1'b0;
    get_velocity      = 1'b0;
    reset_delay       = 1'b0;
    conta_delay       = 1'b0;
    reset_timeout     = 1'b0;
    conta_timeout     = 1'b0;
    jogando           = 1'b0;
    pausado           = 1'b0;
    fim_jogo          = 1'b0;
    case (state_q)
      PREPARA: begin
        zera              = 1'b1;
        reset_ultrasonico = 1'b1;
        reset_delay       = 1'b1;
        reset_timeout     = 1'b1;
      end
      MEDIR: begin
        get_velocity  = 1'b1;
        reset_timeout = 1'b1;
        reset_delay   = 1'b1;
        count_map     = 1'b1;
        jogando       = 1'b1;
      end
      ESPERA_MEDIDA: begin
        conta_timeout = 1'b1;
        count_map     = 1'b1;
        jogando       = 1'b1;
      end
      RECUPERA: begin
        reset_ultrasonico = 1'b1;
        reset_timeout     = 1'b1;
        reset_delay       = 1'b1;
        count_map         = 1'b1;
        jogando           = 1'b1;
      end
      ATRASO: begin
        conta_delay = 1'b1;
        count_map   = 1'b1;
        jogando     = 1'b1;
      end
      PAUSA:   pausado  = 1'b1;
      FIM:     fim_jogo = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_delivery_game_uc.sv
// Testbench for delivery_game_uc: directed walk through the game scenarios,
// then randomized buttons/sensor events compared cycle by cycle against a
// rule-level reference model of the game controller.
module tb_delivery_game_uc;

  localparam int MAXR = 3;

  // Input vector layout: {iniciar, pausar, game_over, ready, timeout, end_delay}
  localparam logic [5:0] I_B = 6'b100000;
  localparam logic [5:0] P_B = 6'b010000;
  localparam logic [5:0] G_B = 6'b001000;
  localparam logic [5:0] R_B = 6'b000100;
  localparam logic [5:0] T_B = 6'b000010;
  localparam logic [5:0] E_B = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, pausar = 1'b0, game_over = 1'b0;
  logic       velocity_ready = 1'b0, velocity_timeout = 1'b0, end_delay = 1'b0;
  logic       zera, reset_ultrasonico, count_map, get_velocity;
  logic       reset_delay, conta_delay, reset_timeout, conta_timeout;
  logic       jogando, pausado, fim_jogo, sensor_fault;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_pass   = 0;

  delivery_game_uc #(.MAX_RETRIES(MAXR)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .game_over(game_over), .velocity_ready(velocity_ready),
    .velocity_timeout(velocity_timeout), .end_delay(end_delay),
    .zera(zera), .reset_ultrasonico(reset_ultrasonico), .count_map(count_map),
    .get_velocity(get_velocity), .reset_delay(reset_delay),
    .conta_delay(conta_delay), .reset_timeout(reset_timeout),
    .conta_timeout(conta_timeout), .jogando(jogando), .pausado(pausado),
    .fim_jogo(fim_jogo), .sensor_fault(sensor_fault), .db_estado(db_estado)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  logic [10:0] out_vec;
  assign out_vec = {zera, reset_ultrasonico, count_map, get_velocity,
                    reset_delay, conta_delay, reset_timeout, conta_timeout,
                    jogando, pausado, fim_jogo};

  // Expected output word for each named game phase, written from the
  // phase descriptions (same bit order as out_vec).
  logic [10:0] phase_outs [8];
  initial begin
    phase_outs[0] = 11'b00000000000; // idle
    phase_outs[1] = 11'b11001010000; // prepare: zera, rst_us, rst_delay, rst_timeout
    phase_outs[2] = 11'b00111010100; // measure request
    phase_outs[3] = 11'b00100001100; // waiting for measurement
    phase_outs[4] = 11'b01101010100; // recover after timeout
    phase_outs[5] = 11'b00100100100; // inter-measurement delay
    phase_outs[6] = 11'b00000000010; // paused
    phase_outs[7] = 11'b00000000001; // game over
  end

  // Reference model: game phase, button history, consecutive timeouts,
  // sticky fault and pending pause.
  int   m_phase;
  logic m_prev_ini, m_prev_pau;
  int   m_timeouts;
  logic m_fault, m_pause_pending;

  // Expected-value queue of state codes produced by the model each cycle.
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_prev_ini = 0; m_prev_pau = 0;
    m_timeouts = 0; m_fault = 0; m_pause_pending = 0;
  endtask

  task automatic model_step(input logic [5:0] v);
    logic ini_e, pau_e, go, rdy, tmo, edl;
    int   nxt;
    bit   playing;
    ini_e = v[5] & ~m_prev_ini;
    pau_e = v[4] & ~m_prev_pau;
    go = v[3]; rdy = v[2]; tmo = v[1]; edl = v[0];
    playing = (m_phase >= 2) && (m_phase <= 5);
    nxt = m_phase;
    if (m_phase == 0 || m_phase == 7) begin
      if (ini_e) nxt = 1;
    end else if (m_phase == 1) nxt = 2;
    else if (m_phase == 2) nxt = 3;
    else if (m_phase == 3) begin
      if (go) nxt = 7; else if (rdy) nxt = 5; else if (tmo) nxt = 4;
    end else if (m_phase == 4) nxt = 5;
    else if (m_phase == 5) begin
      if (go) nxt = 7; else if (edl) nxt = m_pause_pending ? 6 : 2;
    end else if (m_phase == 6) begin
      if (pau_e) nxt = 2;
    end
    if (nxt == 1) begin
      m_timeouts = 0; m_fault = 0; m_pause_pending = 0;
    end else begin
      if (m_phase == 3 && !go && rdy) m_timeouts = 0;
      if (m_phase == 4) begin
        if (m_timeouts < MAXR) m_timeouts++;
        if (m_timeouts == MAXR) m_fault = 1;
      end
      if (nxt == 6) m_pause_pending = 0;
      else if (pau_e && playing) m_pause_pending = 1;
    end
    m_phase = nxt;
    m_prev_ini = v[5];
    m_prev_pau = v[4];
    exp_q.push_back(4'(m_phase));
  endtask

  task automatic compare_all();
    logic [3:0] e;
    e = exp_q.pop_front();
    chk("db_estado", 32'(db_estado), 32'(e));
    chk("outputs", 32'(out_vec), 32'(phase_outs[m_phase]));
    chk("sensor_fault", 32'(sensor_fault), 32'(m_fault));
  endtask

  // Driver: apply inputs after a falling edge, clock once, check at next fall.
  task automatic cyc(input logic [5:0] v);
    {iniciar, pausar, game_over, velocity_ready, velocity_timeout, end_delay} = v;
    @(posedge clock);
    model_step(v);
    @(negedge clock);
    compare_all();
  endtask

  // Assert reset between edges and check the outputs collapse immediately.
  task automatic async_reset(input logic [5:0] v);
    {iniciar, pausar, game_over, velocity_ready, velocity_timeout, end_delay} = v;
    #1 reset = 1'b1;
    #1;
    chk("rst_outputs", 32'(out_vec), 32'd0);
    chk("rst_state", 32'(db_estado), 32'd0);
    chk("rst_fault", 32'(sensor_fault), 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [5:0] rv;
  logic       lvl_ini, lvl_pau;

  initial begin
    model_reset();
    #1;
    chk("por_outputs", 32'(out_vec), 32'd0);
    chk("por_state", 32'(db_estado), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Start sequence 0 -> 1 -> 2 -> 3
    cyc(NONE); chk("plan_idle", 32'(db_estado), 32'd0);
    cyc(I_B);  chk("plan_prep", 32'(db_estado), 32'd1); chk("plan_zera", 32'(zera), 32'd1);
    cyc(I_B);  chk("plan_medir", 32'(db_estado), 32'd2);
    chk("plan_zera_off", 32'(zera), 32'd0); chk("plan_getv", 32'(get_velocity), 32'd1);
    cyc(NONE); chk("plan_espera", 32'(db_estado), 32'd3); chk("plan_getv_off", 32'(get_velocity), 32'd0);

    // Successful measurement then delay expiry
    cyc(R_B);  chk("plan_ready", 32'(db_estado), 32'd5);
    cyc(E_B);  chk("plan_remeasure", 32'(db_estado), 32'd2); chk("plan_getv2", 32'(get_velocity), 32'd1);
    cyc(NONE);

    // Three consecutive timeouts raise the sticky fault
    for (int i = 0; i < 3; i++) begin
      cyc(T_B);  chk("plan_recupera", 32'(db_estado), 32'd4);
      cyc(NONE); chk("plan_fault", 32'(sensor_fault), (i == 2) ? 32'd1 : 32'd0);
      cyc(E_B);  cyc(NONE);
    end
    cyc(R_B); chk("plan_fault_sticky", 32'(sensor_fault), 32'd1);
    cyc(E_B); cyc(NONE);

    // Pause requested mid-measurement, honoured at end of delay
    cyc(P_B);  chk("plan_pause_wait", 32'(db_estado), 32'd3);
    cyc(R_B);
    cyc(E_B);  chk("plan_paused", 32'(db_estado), 32'd6); chk("plan_map_off", 32'(count_map), 32'd0);
    cyc(NONE);
    cyc(P_B);  chk("plan_resume", 32'(db_estado), 32'd2);
    cyc(NONE); cyc(R_B);

    // Collision beats end_delay, restart clears the fault
    cyc(G_B | E_B); chk("plan_fim", 32'(db_estado), 32'd7); chk("plan_fim_out", 32'(fim_jogo), 32'd1);
    cyc(I_B);  chk("plan_restart", 32'(db_estado), 32'd1); chk("plan_fault_clr", 32'(sensor_fault), 32'd0);
    cyc(NONE); cyc(NONE); cyc(R_B);

    // Reset mid-game with iniciar held: restart on first clock after release
    async_reset(I_B);
    cyc(I_B); chk("plan_rst_start", 32'(db_estado), 32'd1);

    // Randomized play
    lvl_ini = 1'b1; lvl_pau = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) lvl_ini = ~lvl_ini;
      if ($urandom_range(0, 9) == 0) lvl_pau = ~lvl_pau;
      rv[5] = lvl_ini;
      rv[4] = lvl_pau;
      rv[3] = ($urandom_range(0, 59) == 0);
      rv[2] = ($urandom_range(0, 4) == 0);
      rv[1] = ($urandom_range(0, 3) == 0);
      rv[0] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) async_reset(rv);
      else cyc(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
